// File: rtl/serializer_piso_if.sv
// Word handshake between an upstream producer and the PISO serializer.
// The producer holds data_in/data_valid stable until data_ready accepts the word.
interface serializer_piso_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serializer_piso.sv
// Parallel-in/serial-out stage with a one-word holding register so that
// consecutive words stream out one bit per clock with no idle gap.
module serializer_piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 nrst,
    serializer_piso_if.slave     up,
    output logic                 serial_out,
    output logic                 bit_valid,
    output logic                 frame_start,
    output logic                 busy
);
    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] sreg_r, sreg_nxt_s, sreg_shift_s;
    logic [WIDTH-1:0] hold_r, hold_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             hold_full_r, hold_full_nxt_s;
    logic             accept_s, last_s;

    // State and datapath registers; reset discards any word in flight or held.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_IDLE;
            sreg_r      <= {WIDTH{1'b0}};
            hold_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            hold_full_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sreg_r      <= sreg_nxt_s;
            hold_r      <= hold_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hold_full_r <= hold_full_nxt_s;
        end
    end

    // Next-state and datapath update: load, shift, hand over from hold, or drain to idle.
    always_comb begin
        accept_s        = up.data_valid && !hold_full_r;
        last_s          = (cnt_r == CNT_LAST);
        sreg_shift_s    = MSB_FIRST ? {sreg_r[WIDTH-2:0], 1'b0} : {1'b0, sreg_r[WIDTH-1:1]};
        state_nxt_s     = state_r;
        sreg_nxt_s      = sreg_r;
        hold_nxt_s      = hold_r;
        cnt_nxt_s       = cnt_r;
        hold_full_nxt_s = hold_full_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sreg_nxt_s  = up.data_in;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    // The held word takes priority; a fresh word can only arrive when hold is empty.
                    if (hold_full_r) begin
                        sreg_nxt_s      = hold_r;
                        hold_full_nxt_s = 1'b0;
                    end else if (accept_s) begin
                        sreg_nxt_s = up.data_in;
                    end else begin
                        sreg_nxt_s  = {WIDTH{1'b0}};
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    sreg_nxt_s = sreg_shift_s;
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                    if (accept_s) begin
                        hold_nxt_s      = up.data_in;
                        hold_full_nxt_s = 1'b1;
                    end else begin
                        hold_full_nxt_s = hold_full_r;
                    end
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                sreg_nxt_s      = {WIDTH{1'b0}};
                cnt_nxt_s       = {CNT_W{1'b0}};
                hold_full_nxt_s = 1'b0;
            end
        endcase
    end

    // Output decode from registered state only; no path from data_valid to data_ready.
    always_comb begin
        bit_valid     = (state_r == ST_SHIFT);
        frame_start   = (state_r == ST_SHIFT) && (cnt_r == {CNT_W{1'b0}});
        busy          = (state_r == ST_SHIFT) || hold_full_r;
        up.data_ready = !hold_full_r;
        if (state_r == ST_SHIFT) begin
            serial_out = MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0];
        end else begin
            serial_out = 1'b0;
        end
    end
endmodule
